mem_spi_flash_responder: RTL and testbench
==========================================

MEM_SPI_FLASH_RESPONDER -- requirements
Module: mem_spi_flash_responder

Interface
REQ-001 Parameter MEM_ADDR_W, default 8: log2 of the byte array depth (256 bytes); address bits above MEM_ADDR_W-1 SHALL be ignored.
REQ-002 Parameter DUMMY_CYCLES, default 8: SCLK cycles between the address and data for opcode 0x6B.
REQ-003 clk  input  1  system clock; SHALL be at least 4x the SCLK frequency.
REQ-004 rst_n  input  1  reset; one clock domain, reset is synchronous and active-low.
REQ-005 in_sclk  input  1  SPI clock from the controller, mode 0 (CPOL=0, CPHA=0).
REQ-006 in_cs_n  input  1  chip select, active low.
REQ-007 in_io  input  4  IO0..IO3 from the controller; IO0 carries MOSI in single mode.
REQ-008 out_io  output  4  IO0..IO3 driven by the responder; IO1 carries MISO in single mode.
REQ-009 out_io_ena  output  4  per-pin output enable, 1 = responder drives the pin.

Function
REQ-010 in_sclk, in_cs_n and in_io SHALL each pass through a 2-flop synchronizer; edges SHALL be detected from the synchronized samples only.
REQ-011 Input bits SHALL be sampled on a detected SCLK rising edge; out_io SHALL update exactly 1 clk after a detected SCLK falling edge.
REQ-012 FSM states: IDLE, CMD, ADDR, DUMMY, DATA_OUT, DATA_IN, STAT_OUT, IGNORE.
REQ-013 Transitions:
- CS falling -> CMD.
- CMD: after 8 bits (MSB first), decode the opcode.
- ADDR: after 24 bits (MSB first) -> DUMMY (0x6B), DATA_OUT (0x03) or DATA_IN (0x02).
- DUMMY: after DUMMY_CYCLES SCLK rising edges -> DATA_OUT.
REQ-014 Opcodes:
- 0x06 WREN: set WEL.
- 0x04 WRDI: clear WEL.
- 0x05 RDSR1: stream SR1 = {6'b0, WEL, WIP=0}.
- 0x35 RDSR2: stream SR2 = {6'b0, QE, 1'b0}.
- 0x31 WRSR2: next byte bit1 -> QE, only if WEL=1.
- 0x03 READ.
- 0x02 PAGE PROGRAM.
- 0x6B QUAD OUTPUT READ: accepted only when QE=1.
REQ-015 Any other opcode, or 0x6B with QE=0, -> IGNORE; out_io_ena SHALL stay 4'b0000 until CS rises.
REQ-016 WREN/WRDI SHALL take effect on the CS rising edge, and only if exactly 8 bits were received.
REQ-017 READ: bytes SHALL be sent MSB first on IO1 starting at the address; the address SHALL increment per byte and wrap from 2^MEM_ADDR_W-1 to 0.
REQ-018 RDSR1/RDSR2: the status byte SHALL repeat for as long as CS stays low.
REQ-019 Quad read: nibbles SHALL be sent high nibble first on IO3..IO0, using the same address increment and wrap as READ.
REQ-020 Drive enables:
- Single-mode output phases: out_io_ena SHALL be 4'b0010.
- Quad DATA_OUT: out_io_ena SHALL be 4'b1111.
- All other states: out_io_ena SHALL be 4'b0000.
REQ-021 PAGE PROGRAM with WEL=1:
- Each complete received byte SHALL be written as mem[a] = mem[a] AND data.
- The address SHALL wrap within the low 8 bits (256-byte page).
REQ-022 PAGE PROGRAM with WEL=0: no array write.
REQ-023 WEL SHALL clear on the CS rising edge that ends PAGE PROGRAM or WRSR2, whether or not data was written.
REQ-024 CS rising in any state -> IDLE within 1 clk of detection; a partial byte SHALL be discarded (no write, no status change).
REQ-025 When CS-rise and SCLK-edge detections fall in the same clk, CS-rise SHALL take priority.
REQ-026 Whenever out_io_ena=0, out_io SHALL be 4'b0000.

Reset
REQ-027 While rst_n=0 at a clk rising edge:
- FSM -> IDLE; WEL=0; QE=0.
- All memory bytes = 8'hFF.
- out_io = 0; out_io_ena = 0.
- Bit and byte counters cleared.
REQ-028 Reset asserted mid-transaction SHALL abort it with no array write; after reset the block SHALL ignore traffic until the next CS falling edge.

Verification
REQ-029 Read after reset: READ 0x03 addr 0x000010, 2 bytes -> 0xFF, 0xFF on IO1; out_io_ena = 4'b0010 during the data phase.
REQ-030 Program: WREN; PP 0x02 addr 0x0000FE with data 0xA5, 0x3C, 0x0F; then READ at 0xFE for 3 bytes -> 0xA5, 0x3C, 0x0F (the third byte lands at 0x00); a following RDSR1 returns 0x00 (WEL cleared).
REQ-031 Protection: PP without WREN, data 0x00 at 0x20 -> READ at 0x20 returns 0xFF; RDSR1 after a lone WREN returns 0x02.
REQ-032 Quad read:
- 0x6B with QE=0 -> out_io_ena stays 0.
- WREN, then WRSR2 with data 0x02 -> RDSR2 returns 0x02.
- 0x6B at the address holding 0xA5 -> nibbles 0xA then 0x5 on IO3..IO0 after 8 dummy clocks.
REQ-033 Aborts:
- CS raised after 5 bits of a PP data byte -> array unchanged.
- rst_n pulsed low mid-READ -> out_io_ena = 0 on the next clk, and all array bytes read back 0xFF.

Source files
------------

// File: rtl/mem_spi_flash_responder.sv
// SPI NOR-flash style responder backed by a small byte array.
// Speaks single-bit READ/PAGE PROGRAM, status read/write and quad output read.
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   in_sclk, in_cs_n  SPI clock (mode 0) and chip select from the controller
//   in_io[3:0]        controller-driven IO0..IO3 (IO0 = MOSI)
//   out_io[3:0]       responder-driven IO0..IO3 (IO1 = MISO in single mode)
//   out_io_ena[3:0]   per-pin output enable
`timescale 1ns/1ps
module mem_spi_flash_responder #(
    parameter int unsigned MEM_ADDR_W   = 8,
    parameter int unsigned DUMMY_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_sclk,
    input  logic       in_cs_n,
    input  logic [3:0] in_io,
    output logic [3:0] out_io,
    output logic [3:0] out_io_ena
);

    localparam int unsigned MEM_DEPTH = 1 << MEM_ADDR_W;
    localparam int unsigned BIT_CNT_W = 5;
    localparam int unsigned DCNT_W    = (DUMMY_CYCLES < 2) ? 1 : $clog2(DUMMY_CYCLES);
    localparam int unsigned PAGE_W    = (MEM_ADDR_W < 8) ? MEM_ADDR_W : 8;
    localparam logic [MEM_ADDR_W-1:0] PAGE_MASK = MEM_ADDR_W'((1 << PAGE_W) - 1);
    localparam logic [DCNT_W-1:0]     DCNT_LAST = DCNT_W'(DUMMY_CYCLES - 1);

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR1 = 8'h05;
    localparam logic [7:0] OP_RDSR2 = 8'h35;
    localparam logic [7:0] OP_WRSR2 = 8'h31;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_PP    = 8'h02;
    localparam logic [7:0] OP_QREAD = 8'h6B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA_OUT,
        S_DATA_IN,
        S_STAT_OUT,
        S_IGNORE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]            r_sclk_sync;
    logic [1:0]            r_cs_sync;
    logic [3:0]            r_io_sync0;
    logic [3:0]            r_io_sync1;
    logic                  r_sclk_prev;
    logic                  r_cs_prev;

    logic [23:0]           r_shift;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [DCNT_W-1:0]     r_dcnt;
    logic [2:0]            r_tx_idx;
    logic [7:0]            r_opcode;
    logic [MEM_ADDR_W-1:0] r_addr;
    logic                  r_wel;
    logic                  r_qe;
    logic                  r_extra;
    logic [3:0]            r_out_io;
    logic [3:0]            r_out_ena;
    logic [7:0]            r_mem [MEM_DEPTH];

    logic                  w_sclk_rise;
    logic                  w_sclk_fall;
    logic                  w_cs_rise;
    logic                  w_cs_fall;
    logic                  w_mosi;
    logic                  w_unused_io;
    logic [23:0]           w_shift_in;
    logic [7:0]            w_rx_byte;
    logic [7:0]            w_mem_byte;
    logic [7:0]            w_status;
    logic [MEM_ADDR_W-1:0] w_pp_next_addr;
    logic [3:0]            w_ena_nxt;

    // Input synchronizers; CS and SCLK reset low so that a transaction already
    // in flight at reset release never produces a spurious CS falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk_sync <= 2'b00;
            r_cs_sync   <= 2'b00;
            r_io_sync0  <= 4'b0000;
            r_io_sync1  <= 4'b0000;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], in_sclk};
            r_cs_sync   <= {r_cs_sync[0], in_cs_n};
            r_io_sync0  <= in_io;
            r_io_sync1  <= r_io_sync0;
            r_sclk_prev <= r_sclk_sync[1];
            r_cs_prev   <= r_cs_sync[1];
        end
    end

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_prev;
    assign w_cs_rise   = r_cs_sync[1] & ~r_cs_prev;
    assign w_cs_fall   = ~r_cs_sync[1] & r_cs_prev;
    assign w_mosi      = r_io_sync1[0];
    // IO1..IO3 are synchronized but carry nothing this responder consumes.
    assign w_unused_io = ^r_io_sync1[3:1];

    assign w_shift_in     = {r_shift[22:0], w_mosi};
    assign w_rx_byte      = w_shift_in[7:0];
    assign w_mem_byte     = r_mem[r_addr];
    assign w_status       = (r_opcode == OP_RDSR1) ? {6'b0, r_wel, 1'b0} : {6'b0, r_qe, 1'b0};
    // Page program wraps inside the 256-byte page, upper address bits held.
    assign w_pp_next_addr = (r_addr & ~PAGE_MASK) | ((r_addr + MEM_ADDR_W'(1)) & PAGE_MASK);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next output-enable; CS rising overrides any SCLK edge.
    always_comb begin
        w_state_nxt = r_state;
        w_ena_nxt   = 4'b0000;
        if (w_cs_rise) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) w_state_nxt = S_CMD;
                end
                S_CMD: begin
                    if (w_sclk_rise && r_bit_cnt == BIT_CNT_W'(7)) begin
                        case (w_rx_byte)
                            OP_RDSR1, OP_RDSR2: w_state_nxt = S_STAT_OUT;
                            OP_WRSR2:           w_state_nxt = S_DATA_IN;
                            OP_READ, OP_PP:     w_state_nxt = S_ADDR;
                            OP_QREAD:           w_state_nxt = r_qe ? S_ADDR : S_IGNORE;
                            default:            w_state_nxt = S_IGNORE;
                        endcase
                    end
                end
                S_ADDR: begin
                    if (w_sclk_rise && r_bit_cnt == BIT_CNT_W'(23)) begin
                        case (r_opcode)
                            OP_QREAD: w_state_nxt = (DUMMY_CYCLES == 0) ? S_DATA_OUT : S_DUMMY;
                            OP_READ:  w_state_nxt = S_DATA_OUT;
                            default:  w_state_nxt = S_DATA_IN;
                        endcase
                    end
                end
                S_DUMMY: begin
                    if (w_sclk_rise && r_dcnt == DCNT_LAST) w_state_nxt = S_DATA_OUT;
                end
                default: ;
            endcase
        end

        case (w_state_nxt)
            S_STAT_OUT: w_ena_nxt = 4'b0010;
            S_DATA_OUT: w_ena_nxt = (r_opcode == OP_QREAD) ? 4'b1111 : 4'b0010;
            default:    w_ena_nxt = 4'b0000;
        endcase
    end

    // Datapath: shift-in on SCLK rise, shift-out on SCLK fall, commit on CS rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_dcnt    <= '0;
            r_tx_idx  <= '0;
            r_opcode  <= '0;
            r_addr    <= '0;
            r_wel     <= 1'b0;
            r_qe      <= 1'b0;
            r_extra   <= 1'b0;
            r_out_io  <= 4'b0000;
            r_out_ena <= 4'b0000;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= 8'hFF;
            end
        end else begin
            r_out_ena <= w_ena_nxt;
            if (w_cs_rise) begin
                // r_opcode is zero unless a full opcode byte was decoded.
                case (r_opcode)
                    OP_WREN:         if (!r_extra) r_wel <= 1'b1;
                    OP_WRDI:         if (!r_extra) r_wel <= 1'b0;
                    OP_PP, OP_WRSR2: r_wel <= 1'b0;
                    default: ;
                endcase
                r_bit_cnt <= '0;
            end else if (r_state == S_IDLE && w_cs_fall) begin
                r_opcode  <= '0;
                r_bit_cnt <= '0;
                r_dcnt    <= '0;
                r_tx_idx  <= '0;
                r_extra   <= 1'b0;
            end else if (w_sclk_rise) begin
                case (r_state)
                    S_CMD: begin
                        r_shift   <= w_shift_in;
                        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                        if (r_bit_cnt == BIT_CNT_W'(7)) begin
                            r_opcode  <= w_rx_byte;
                            r_bit_cnt <= '0;
                            r_tx_idx  <= '0;
                        end
                    end
                    S_ADDR: begin
                        r_shift   <= w_shift_in;
                        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                        if (r_bit_cnt == BIT_CNT_W'(23)) begin
                            r_addr    <= w_shift_in[MEM_ADDR_W-1:0];
                            r_bit_cnt <= '0;
                            r_dcnt    <= '0;
                            r_tx_idx  <= '0;
                        end
                    end
                    S_DUMMY: begin
                        r_dcnt <= r_dcnt + DCNT_W'(1);
                    end
                    S_DATA_IN: begin
                        r_shift   <= w_shift_in;
                        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                        if (r_bit_cnt == BIT_CNT_W'(7)) begin
                            r_bit_cnt <= '0;
                            r_extra   <= 1'b1;
                            if (r_opcode == OP_PP) begin
                                if (r_wel) r_mem[r_addr] <= w_mem_byte & w_rx_byte;
                                r_addr <= w_pp_next_addr;
                            end else if (r_wel && !r_extra) begin
                                r_qe <= w_rx_byte[1];
                            end
                        end
                    end
                    S_IGNORE: begin
                        // Any bit past the opcode disqualifies WREN/WRDI.
                        r_extra <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (w_sclk_fall) begin
                case (r_state)
                    S_DATA_OUT: begin
                        r_tx_idx <= r_tx_idx + 3'(1);
                        if (r_opcode == OP_QREAD) begin
                            r_out_io <= r_tx_idx[0] ? w_mem_byte[3:0] : w_mem_byte[7:4];
                            if (r_tx_idx[0]) r_addr <= r_addr + MEM_ADDR_W'(1);
                        end else begin
                            r_out_io <= {2'b00, w_mem_byte[~r_tx_idx], 1'b0};
                            if (r_tx_idx == 3'd7) r_addr <= r_addr + MEM_ADDR_W'(1);
                        end
                    end
                    S_STAT_OUT: begin
                        r_out_io <= {2'b00, w_status[~r_tx_idx], 1'b0};
                        r_tx_idx <= r_tx_idx + 3'(1);
                    end
                    default: ;
                endcase
            end
            // Pins are released and quiet whenever the drivers are off.
            if (w_ena_nxt == 4'b0000) r_out_io <= 4'b0000;
        end
    end

    assign out_io     = r_out_io;
    assign out_io_ena = r_out_ena;

endmodule

// File: tb/tb_mem_spi_flash_responder.sv
// Testbench for mem_spi_flash_responder: directed flash transactions plus a
// randomized command mix, checked against a transaction-level flash model.
`timescale 1ns/1ps
module tb_mem_spi_flash_responder;

    localparam int unsigned HALF = 5;

    logic       clk;
    logic       rst_n;
    logic       in_sclk;
    logic       in_cs_n;
    logic [3:0] in_io;
    logic [3:0] out_io;
    logic [3:0] out_io_ena;

    int         n_checks;
    int         n_errors;
    int         ena_bad;
    logic [7:0] model_mem [256];
    logic       model_wel;
    logic       model_qe;
    logic [7:0] pp_buf [4];

    mem_spi_flash_responder #(.MEM_ADDR_W(8), .DUMMY_CYCLES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_sclk    (in_sclk),
        .in_cs_n    (in_cs_n),
        .in_io      (in_io),
        .out_io     (out_io),
        .out_io_ena (out_io_ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) model_mem[i] = 8'hFF;
        model_wel = 1'b0;
        model_qe  = 1'b0;
    endfunction

    // One mode-0 bit: present MOSI while SCLK low, sample pins, rise, fall.
    task automatic xfer_bit(input logic mosi, output logic [3:0] io_s, output logic [3:0] ena_s);
        in_io = {3'b000, mosi};
        repeat (HALF) @(negedge clk);
        io_s  = out_io;
        ena_s = out_io_ena;
        in_sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        in_sclk = 1'b0;
    endtask

    task automatic begin_tx();
        in_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic end_tx();
        repeat (HALF) @(negedge clk);
        in_cs_n = 1'b1;
        in_io   = 4'b0000;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] io_s, ena_s;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], io_s, ena_s);
    endtask

    task automatic send_addr(input logic [23:0] a);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        logic [3:0] io_s, ena_s;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b0, io_s, ena_s);
            b[i] = io_s[1];
            if (ena_s !== 4'b0010) ena_bad++;
        end
    endtask

    task automatic recv_nib(output logic [3:0] n);
        logic [3:0] ena_s;
        xfer_bit(1'b0, n, ena_s);
        if (ena_s !== 4'b1111) ena_bad++;
    endtask

    task automatic op_simple(input logic [7:0] opc);
        begin_tx();
        send_byte(opc);
        end_tx();
        if (opc == 8'h06) model_wel = 1'b1;
        if (opc == 8'h04) model_wel = 1'b0;
    endtask

    task automatic op_read(input logic [23:0] a, input int n, input string tag);
        logic [7:0] b;
        begin_tx();
        send_byte(8'h03);
        send_addr(a);
        ena_bad = 0;
        for (int i = 0; i < n; i++) begin
            recv_byte(b);
            check_eq($sformatf("%s_b%0d", tag, i), b, model_mem[8'(a + i)]);
        end
        end_tx();
        check_eq({tag, "_ena"}, ena_bad, 0);
    endtask

    task automatic op_pp(input logic [23:0] a, input int n);
        begin_tx();
        send_byte(8'h02);
        send_addr(a);
        for (int i = 0; i < n; i++) send_byte(pp_buf[i]);
        end_tx();
        if (model_wel) begin
            for (int i = 0; i < n; i++) model_mem[8'(a + i)] &= pp_buf[i];
        end
        model_wel = 1'b0;
    endtask

    task automatic op_rdsr(input logic [7:0] opc, input string tag);
        logic [7:0] b;
        logic [7:0] exp;
        exp = (opc == 8'h05) ? {6'b0, model_wel, 1'b0} : {6'b0, model_qe, 1'b0};
        begin_tx();
        send_byte(opc);
        ena_bad = 0;
        for (int i = 0; i < 2; i++) begin
            recv_byte(b);
            check_eq($sformatf("%s_r%0d", tag, i), b, exp);
        end
        end_tx();
        check_eq({tag, "_ena"}, ena_bad, 0);
    endtask

    task automatic op_wrsr2(input logic [7:0] d);
        begin_tx();
        send_byte(8'h31);
        send_byte(d);
        end_tx();
        if (model_wel) model_qe = d[1];
        model_wel = 1'b0;
    endtask

    task automatic op_quad(input logic [23:0] a, input int n, input string tag);
        logic [3:0] io_s, ena_s, nib;
        int quiet_bad;
        begin_tx();
        send_byte(8'h6B);
        send_addr(a);
        quiet_bad = 0;
        if (model_qe) begin
            for (int i = 0; i < 8; i++) begin
                xfer_bit(1'b0, io_s, ena_s);
                if (ena_s !== 4'b0000) quiet_bad++;
            end
            ena_bad = 0;
            for (int i = 0; i < n; i++) begin
                recv_nib(nib);
                check_eq($sformatf("%s_hi%0d", tag, i), nib, model_mem[8'(a + i)] >> 4);
                recv_nib(nib);
                check_eq($sformatf("%s_lo%0d", tag, i), nib, model_mem[8'(a + i)] & 8'h0F);
            end
            check_eq({tag, "_ena"}, ena_bad, 0);
        end else begin
            for (int i = 0; i < 16; i++) begin
                xfer_bit(1'b0, io_s, ena_s);
                if (ena_s !== 4'b0000 || io_s !== 4'b0000) quiet_bad++;
            end
        end
        end_tx();
        check_eq({tag, "_quiet"}, quiet_bad, 0);
    endtask

    initial begin
        logic [3:0] io_s, ena_s;
        logic [7:0] b;
        int bad;
        int op;

        n_checks = 0;
        n_errors = 0;
        ena_bad  = 0;
        rst_n    = 1'b0;
        in_sclk  = 1'b0;
        in_cs_n  = 1'b1;
        in_io    = 4'b0000;
        model_reset();
        repeat (5) @(negedge clk);
        check_eq("rst_ena", out_io_ena, 4'b0000);
        check_eq("rst_io", out_io, 4'b0000);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Read of erased array
        op_read(24'h000010, 2, "rd_after_rst");

        // Program across the page boundary, then read back and check WEL
        op_simple(8'h06);
        pp_buf[0] = 8'hA5; pp_buf[1] = 8'h3C; pp_buf[2] = 8'h0F;
        op_pp(24'h0000FE, 3);
        op_read(24'h0000FE, 3, "rd_prog");
        op_rdsr(8'h05, "sr1_after_pp");

        // Write protection and WEL handling
        pp_buf[0] = 8'h00;
        op_pp(24'h000020, 1);
        op_read(24'h000020, 1, "rd_protect");
        op_simple(8'h06);
        op_rdsr(8'h05, "sr1_wren");
        op_simple(8'h04);
        op_rdsr(8'h05, "sr1_wrdi");

        // WREN with a ninth bit must not set WEL
        begin_tx();
        send_byte(8'h06);
        xfer_bit(1'b1, io_s, ena_s);
        end_tx();
        op_rdsr(8'h05, "sr1_wren9");

        // Quad enable and quad read
        op_quad(24'h0000FE, 1, "quad_qe0");
        op_wrsr2(8'h02);
        op_rdsr(8'h35, "sr2_nowel");
        op_simple(8'h06);
        op_wrsr2(8'h02);
        op_rdsr(8'h35, "sr2_qe");
        op_quad(24'h0000FE, 2, "quad_rd");

        // Partial data byte is discarded; WEL still clears
        op_simple(8'h06);
        begin_tx();
        send_byte(8'h02);
        send_addr(24'h000040);
        for (int i = 0; i < 5; i++) xfer_bit(1'b0, io_s, ena_s);
        end_tx();
        model_wel = 1'b0;
        op_read(24'h000040, 1, "rd_abort");
        op_rdsr(8'h05, "sr1_abort");

        // Randomized command mix
        for (int k = 0; k < 16; k++) begin
            op = int'($urandom_range(0, 7));
            case (op)
                0: op_simple(8'h06);
                1: op_simple(8'h04);
                2: begin
                    if ($urandom_range(0, 3) != 0) op_simple(8'h06);
                    for (int i = 0; i < 4; i++) pp_buf[i] = 8'($urandom | $urandom);
                    op_pp(24'($urandom), int'($urandom_range(1, 3)));
                end
                3: op_read(24'($urandom), int'($urandom_range(1, 3)), $sformatf("rnd%0d_rd", k));
                4: op_rdsr(8'h05, $sformatf("rnd%0d_sr1", k));
                5: op_rdsr(8'h35, $sformatf("rnd%0d_sr2", k));
                6: begin
                    if ($urandom_range(0, 1) != 0) op_simple(8'h06);
                    op_wrsr2(8'($urandom));
                end
                default: op_quad(24'($urandom), int'($urandom_range(1, 2)), $sformatf("rnd%0d_qd", k));
            endcase
        end

        // Reset in the middle of a READ
        begin_tx();
        send_byte(8'h03);
        send_addr(24'h0000FE);
        ena_bad = 0;
        recv_byte(b);
        check_eq("rstmid_b0", b, model_mem[8'hFE]);
        for (int i = 0; i < 3; i++) xfer_bit(1'b0, io_s, ena_s);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rstmid_ena", out_io_ena, 4'b0000);
        check_eq("rstmid_io", out_io, 4'b0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            xfer_bit(1'b0, io_s, ena_s);
            if (ena_s !== 4'b0000) bad++;
        end
        end_tx();
        check_eq("rstmid_quiet", bad, 0);
        op_rdsr(8'h35, "sr2_after_rst");
        op_rdsr(8'h05, "sr1_after_rst");

        // Whole array reads back erased, wrapping once past 0xFF
        begin_tx();
        send_byte(8'h03);
        send_addr(24'h000080);
        ena_bad = 0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            recv_byte(b);
            if (b !== model_mem[8'(8'h80 + i)]) bad++;
        end
        end_tx();
        check_eq("wipe_bad_bytes", bad, 0);
        check_eq("wipe_ena", ena_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
